mbist_march_ctrl: RTL and testbench



---
 rtl/mbist_march_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller for a single-port RAM whose read data lags its address by one edge.
// Optional build macro MBIST_STOP_ON_FAIL_EN: end the run on the edge after the first mismatch.
module mbist_march_ctrl #(
  parameter int                ADDR_W     = 6,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] BG_PATTERN = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramin,
  output logic              we,
  input  logic [DATA_W-1:0] ramout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH, S_DONE
  } state_t;

`ifdef MBIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] BG0       = BG_PATTERN;
  localparam logic [DATA_W-1:0] BG1       = ~BG_PATTERN;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_phase;
  logic                r_we;
  logic [DATA_W-1:0]   r_ramin;
  logic                r_busy;
  logic                r_done;
  logic                r_fail;
  logic [ADDR_W-1:0]   r_fail_addr;
  logic [DATA_W-1:0]   r_fail_data;
  logic                r_exp_valid;
  logic [DATA_W-1:0]   r_exp_data;
  logic [ADDR_W-1:0]   r_exp_addr;

  logic                w_down;
  logic                w_terminal;
  logic                w_read;
  logic                w_mismatch;
  logic [ADDR_W-1:0]   w_step_addr;
  logic [ADDR_W-1:0]   w_reload;
  logic [DATA_W-1:0]   w_rd_exp;
  logic [DATA_W-1:0]   w_wr_val;
  state_t              w_next_elem;

  // Per-element direction, data values and successor element.
  always_comb begin
    w_down      = (r_state == S_M3) || (r_state == S_M4);
    w_terminal  = w_down ? (r_addr == '0) : (r_addr == ADDR_LAST);
    w_step_addr = w_down ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
    w_read      = 1'b0;
    w_rd_exp    = BG0;
    w_wr_val    = BG0;
    w_next_elem = S_FLUSH;
    w_reload    = '0;
    case (r_state)
      S_M0: w_next_elem = S_M1;
      S_M1: begin
        w_read = !r_phase; w_rd_exp = BG0; w_wr_val = BG1;
        w_next_elem = S_M2;
      end
      S_M2: begin
        w_read = !r_phase; w_rd_exp = BG1; w_wr_val = BG0;
        w_next_elem = S_M3; w_reload = ADDR_LAST;
      end
      S_M3: begin
        w_read = !r_phase; w_rd_exp = BG0; w_wr_val = BG1;
        w_next_elem = S_M4; w_reload = ADDR_LAST;
      end
      S_M4: begin
        w_read = !r_phase; w_rd_exp = BG1; w_wr_val = BG0;
        w_next_elem = S_M5;
      end
      S_M5: begin
        w_read = 1'b1; w_rd_exp = BG0;
      end
      default: ;
    endcase
  end

  // NOTE: ramout answers the address issued one cycle earlier, so it is checked
  // against the expectation registered on that read cycle, not the current state.
  assign w_mismatch = r_exp_valid && (ramout != r_exp_data);

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; later assignments in the block deliberately override earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_phase     <= 1'b0;
      r_we        <= 1'b0;
      r_ramin     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_exp_valid <= 1'b0;
      r_exp_data  <= '0;
      r_exp_addr  <= '0;
    end else begin
      r_exp_valid <= w_read;
      r_exp_data  <= w_rd_exp;
      r_exp_addr  <= r_addr;

      if (w_mismatch && !r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= r_exp_addr;
        r_fail_data <= ramout;
      end

      if (STOP_ON_FAIL && w_mismatch) begin
        r_state     <= S_DONE;
        r_we        <= 1'b0;
        r_busy      <= 1'b0;
        r_done      <= 1'b1;
        r_exp_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_state     <= S_M0;
              r_addr      <= '0;
              r_phase     <= 1'b0;
              r_we        <= 1'b1;
              r_ramin     <= BG0;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
              r_fail      <= 1'b0;
              r_fail_addr <= '0;
              r_fail_data <= '0;
            end
          end
          S_M0: begin
            r_ramin <= w_wr_val;
            if (w_terminal) begin
              r_state <= w_next_elem;
              r_addr  <= w_reload;
              r_we    <= 1'b0;
            end else begin
              r_addr <= w_step_addr;
              r_we   <= 1'b1;
            end
          end
          S_M1, S_M2, S_M3, S_M4: begin
            if (!r_phase) begin
              r_phase <= 1'b1;
              r_we    <= 1'b1;
              r_ramin <= w_wr_val;
            end else begin
              r_phase <= 1'b0;
              r_we    <= 1'b0;
              if (w_terminal) begin
                r_state <= w_next_elem;
                r_addr  <= w_reload;
              end else begin
                r_addr <= w_step_addr;
              end
            end
          end
          S_M5: begin
            if (w_terminal) r_state <= S_FLUSH;
            else            r_addr  <= w_step_addr;
          end
          S_FLUSH: begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ramaddr   = r_addr;
  assign ramin     = r_ramin;
  assign we        = r_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: stuck-at RAM model, table-driven and random fault runs
// checked against an element-by-element March C- model.
module tb_mbist_march_ctrl;

  localparam int          AW    = 6;
  localparam int          DW    = 8;
  localparam int          DEPTH = 64;
  localparam logic [7:0]  BG    = 8'h00;
`ifdef MBIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramin;
  logic          we;
  logic [DW-1:0] ramout;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  always #5 clk = ~clk;

  mbist_march_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ramaddr(ramaddr), .ramin(ramin), .we(we), .ramout(ramout),
    .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  // RAM with registered address and an optional stuck-at cell.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [AW-1:0] ram_aq;
  logic [AW-1:0] f_addr = '0;
  logic [DW-1:0] f_sa0 = '0;
  logic [DW-1:0] f_sa1 = '0;

  always @(posedge clk) begin
    if (we) ram_mem[ramaddr] <= ramin;
    ram_aq <= ramaddr;
  end

  always_comb begin
    ramout = ram_mem[ram_aq];
    if (ram_aq == f_addr) ramout = (ramout & ~f_sa0) | f_sa1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural March C- model: expected bus per cycle and run outcome.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
  } op_t;

  op_t           exp_ops[$];
  logic          m_fail;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_done;
  int            m_we;

  function automatic logic [DW-1:0] cell_read(input logic [DW-1:0] v, input logic [AW-1:0] a);
    return (a == f_addr) ? ((v & ~f_sa0) | f_sa1) : v;
  endfunction

  task automatic build_model();
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] wr_v [6];
    logic [DW-1:0] rd_v [6];
    logic [AW-1:0] a;
    logic [DW-1:0] got;
    int cyc, cmp_cyc;
    wr_v = '{BG, ~BG, BG, ~BG, BG, BG};
    rd_v = '{BG, BG, ~BG, BG, ~BG, BG};
    exp_ops.delete();
    m_fail = 1'b0; m_addr = '0; m_data = '0;
    cyc = 0; cmp_cyc = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < DEPTH; k++) begin
        a = AW'((e == 3 || e == 4) ? DEPTH - 1 - k : k);
        if (e > 0) begin
          cyc++;
          exp_ops.push_back(op_t'{a, 1'b0, '0});
          got = cell_read(mem[a], a);
          if (!m_fail && got != rd_v[e]) begin
            m_fail = 1'b1; m_addr = a; m_data = got; cmp_cyc = cyc + 1;
          end
        end
        if (e < 5) begin
          cyc++;
          exp_ops.push_back(op_t'{a, 1'b1, wr_v[e]});
          mem[a] = wr_v[e];
        end
      end
    end
    m_done = (STOP && m_fail) ? cmp_cyc + 1 : cyc + 2;
    m_we = 0;
    for (int i = 0; i < exp_ops.size() && i + 1 < m_done; i++)
      if (exp_ops[i].we) m_we++;
  endtask

  // One start pulse, then per-cycle bus comparison until done (bounded).
  task automatic run_test(input string name, input bit mid_start, input logic exp_fail,
                          input logic [AW-1:0] exp_fa, input logic [DW-1:0] exp_fd,
                          input int exp_done, input int exp_we);
    int cyc, we_cnt, bad;
    bit seen;
    op_t op;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({name, "_start_state"}, {29'd0, busy, done, fail}, 32'b100);
    check({name, "_start_clear"}, {18'd0, fail_addr, fail_data}, 32'd0);
    cyc = 1; we_cnt = 0; bad = 0; seen = 1'b0;
    while (cyc < 1000) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (we) we_cnt++;
      if (cyc <= exp_ops.size()) begin
        op = exp_ops[cyc-1];
        if (ramaddr !== op.addr || we !== op.we || (op.we && ramin !== op.data)) bad++;
      end else if (we !== 1'b0 || busy !== 1'b1) begin
        bad++;
      end
      start = mid_start && (cyc == 100);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_done_cycle"}, cyc, exp_done);
    check({name, "_bus_trace_bad_cycles"}, bad, 0);
    check({name, "_we_count"}, we_cnt, exp_we);
    check({name, "_done_outputs"}, {29'd0, busy, done, we}, 32'b010);
    check({name, "_fail"}, {31'd0, fail}, {31'd0, exp_fail});
    check({name, "_fail_addr"}, {26'd0, fail_addr}, {26'd0, exp_fa});
    check({name, "_fail_data"}, {24'd0, fail_data}, {24'd0, exp_fd});
  endtask

  typedef struct {
    string         name;
    logic [AW-1:0] fa;
    logic [DW-1:0] sa0;
    logic [DW-1:0] sa1;
    bit            mid;
    logic          exp_fail;
    logic [AW-1:0] exp_fa;
    logic [DW-1:0] exp_fd;
    int            exp_done;
    int            exp_we;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bitn, we_rst;
    vecs[0] = '{"clean_midstart", 6'd0,  8'h00, 8'h00, 1'b1, 1'b0, 6'd0,  8'h00, 642, 320};
    vecs[1] = '{"sa1_b0_a5",      6'd5,  8'h00, 8'h01, 1'b0, 1'b1, 6'd5,  8'h01,
                STOP ? 77 : 642,  STOP ? 70 : 320};
    vecs[2] = '{"sa0_b7_a63",     6'd63, 8'h80, 8'h00, 1'b0, 1'b1, 6'd63, 8'h7F,
                STOP ? 321 : 642, STOP ? 192 : 320};
    vecs[3] = '{"clean_after_fail", 6'd0, 8'h00, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 642, 320};

    repeat (2) @(negedge clk);
    check("reset_outputs", {ramaddr, ramin, we, busy, done, fail, fail_addr, fail_data}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold", {29'd0, busy, done, we}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      f_addr = vecs[i].fa; f_sa0 = vecs[i].sa0; f_sa1 = vecs[i].sa1;
      build_model();
      run_test(vecs[i].name, vecs[i].mid, vecs[i].exp_fail, vecs[i].exp_fa,
               vecs[i].exp_fd, vecs[i].exp_done, vecs[i].exp_we);
    end

    for (int r = 0; r < 6; r++) begin
      f_addr = AW'($urandom_range(0, DEPTH - 1));
      bitn   = int'($urandom_range(0, DW - 1));
      f_sa0  = '0; f_sa1 = '0;
      if ($urandom_range(0, 1) == 1) f_sa1[bitn] = 1'b1;
      else                           f_sa0[bitn] = 1'b1;
      build_model();
      run_test($sformatf("rand%0d", r), 1'b0, m_fail, m_addr, m_data, m_done, m_we);
    end

    // Reset in the middle of a run.
    f_sa0 = '0; f_sa1 = '0;
    build_model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (299) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {ramaddr, ramin, we, busy, done, fail, fail_addr, fail_data}, 32'd0);
    we_rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (we) we_rst++;
    end
    check("reset_no_writes", we_rst, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_test("after_reset", 1'b0, 1'b0, '0, '0, 642, 320);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
